// File: rtl/uart_tx_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_arbiter_pkg                                              |
// | Brief   : Shared types, defaults and winner-select helper for the arbiter  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_tx_arbiter_pkg;

    localparam int c_DATA_W  = 8;
    localparam int c_TMO_W   = 8;
    localparam int c_TMO_MAX = 200;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Pointer side wins when it is requesting, otherwise the other side.
    function automatic logic pick_winner(input logic rr_ptr, input logic valid0,
                                         input logic valid1);
        return rr_ptr ? valid1 : ~valid0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_arbiter_if                                               |
// | Brief   : Requester handshakes plus UART TX FIFO write port bundle         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
);
    logic              valid0;
    logic [DATA_W-1:0] data0;
    logic              last0;
    logic              ack0;
    logic              valid1;
    logic [DATA_W-1:0] data1;
    logic              last1;
    logic              ack1;
    logic              tx_full;
    logic              wr_uart;
    logic [DATA_W-1:0] w_data;

    // Environment side: both requesters and the FIFO.
    modport master (
        output valid0, data0, last0, valid1, data1, last1, tx_full,
        input  ack0, ack1, wr_uart, w_data
    );

    // Arbiter side.
    modport slave (
        input  valid0, data0, last0, valid1, data1, last1, tx_full,
        output ack0, ack1, wr_uart, w_data
    );

endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter_stall_timer.sv
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_arbiter_stall_timer                                      |
// | Brief   : Owner-idle counter; flags expiry on the TMO_MAX-th idle cycle    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter_stall_timer #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_count_en,
    output logic      o_expire
);

    localparam logic [TMO_W-1:0] c_LAST = TMO_W'(TMO_MAX - 1);

    logic [TMO_W-1:0] r_count;

    assign o_expire = i_count_en & (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_arbiter                                                  |
// | Brief   : Round-robin, packet-locked sharing of one UART TX FIFO port      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int TMO_W   = c_TMO_W,
    parameter int TMO_MAX = c_TMO_MAX
) (
    input  wire logic        clk,
    input  wire logic        reset,
    uart_tx_arbiter_if.slave arb,
    output logic             busy,
    output logic             owner,
    output logic             abort_tick
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              w_owner_nxt;
    logic              r_rr_ptr;
    logic              w_rr_ptr_nxt;

    logic              w_busy;
    logic              w_own_valid;
    logic              w_own_last;
    logic [DATA_W-1:0] w_own_data;
    logic              w_ack;
    logic              w_expire;
    logic              w_timer_clear;
    logic              w_timer_count;

    assign w_busy      = (r_state == ST_BUSY);
    assign w_own_valid = r_owner ? arb.valid1 : arb.valid0;
    assign w_own_last  = r_owner ? arb.last1  : arb.last0;
    assign w_own_data  = r_owner ? arb.data1  : arb.data0;

    // FIFO back-pressure stalls the owner without touching the timer.
    assign w_ack         = w_busy & w_own_valid & ~arb.tx_full;
    assign w_timer_clear = ~w_busy | w_ack;
    assign w_timer_count = w_busy & ~w_own_valid;

    assign arb.ack0    = w_ack & ~r_owner;
    assign arb.ack1    = w_ack &  r_owner;
    assign arb.wr_uart = w_ack;
    assign arb.w_data  = w_busy ? w_own_data : '0;

    assign busy       = w_busy;
    assign owner      = r_owner;
    assign abort_tick = w_expire;

    uart_tx_arbiter_stall_timer #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_stall_timer (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_timer_clear),
        .i_count_en (w_timer_count),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (arb.valid0 || arb.valid1) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = pick_winner(r_rr_ptr, arb.valid0, arb.valid1);
                end
            end
            ST_BUSY: begin
                // Completed packet and timeout both hand priority to the other side.
                if ((w_ack && w_own_last) || w_expire) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = ~r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_rr_ptr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_tx_arbiter                                               |
// | Brief   : Directed self-checking bench for uart_tx_arbiter                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int c_TMO_MAX = 200;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic owner;
    logic abort_tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] log_q[$];

    uart_tx_arbiter_if #(.DATA_W(8)) bus ();

    uart_tx_arbiter #(
        .DATA_W  (8),
        .TMO_W   (8),
        .TMO_MAX (c_TMO_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arb        (bus.slave),
        .busy       (busy),
        .owner      (owner),
        .abort_tick (abort_tick)
    );

    always #5 clk = ~clk;

    // Every byte written into the FIFO, in order.
    always @(negedge clk) begin
        if (bus.wr_uart === 1'b1) log_q.push_back(bus.w_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid0  = 1'b0;
        bus.data0   = 8'h00;
        bus.last0   = 1'b0;
        bus.valid1  = 1'b0;
        bus.data1   = 8'h00;
        bus.last1   = 1'b0;
        bus.tx_full = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Two well-behaved requesters streaming bytes; l0/l1 mark packet-final bytes with '1'.
    task automatic run_streams(input string s0, input string l0, input string s1,
                               input string l1, input int budget, output int ack1_open);
        int   i0 = 0;
        int   i1 = 0;
        int   n  = 0;
        logic a0;
        logic a1;
        ack1_open = 0;
        while ((i0 < s0.len() || i1 < s1.len()) && n < budget) begin
            bus.valid0 = (i0 < s0.len());
            bus.data0  = (i0 < s0.len()) ? s0[i0] : 8'h00;
            bus.last0  = (i0 < s0.len()) && (l0[i0] == "1");
            bus.valid1 = (i1 < s1.len());
            bus.data1  = (i1 < s1.len()) ? s1[i1] : 8'h00;
            bus.last1  = (i1 < s1.len()) && (l1[i1] == "1");
            #1;
            a0 = bus.ack0;
            a1 = bus.ack1;
            if (a1 && i0 > 0 && i0 < s0.len()) ack1_open++;
            cyc();
            n++;
            if (a0) i0++;
            if (a1) i1++;
        end
        check("stream_complete", 32'((i0 == s0.len()) && (i1 == s1.len())), 32'd1);
        idle_inputs();
    endtask

    task automatic check_log(input string tag, input string exp);
        check({tag, "_count"}, 32'(log_q.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < log_q.size()) ? 32'(log_q[i]) : 32'hffff_ffff, 32'(exp[i]));
        end
    endtask

    initial begin
        int   open1;
        int   bad;
        int   n_abort;

        // ---- 1: reset state, single-byte packet ----
        do_reset();
        #1;
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_owner",   32'(owner),       32'd0);
        check("rst_wr",      32'(bus.wr_uart), 32'd0);
        check("rst_ack0",    32'(bus.ack0),    32'd0);
        check("rst_ack1",    32'(bus.ack1),    32'd0);
        check("rst_abort",   32'(abort_tick),  32'd0);
        check("rst_wdata",   32'(bus.w_data),  32'd0);
        bus.valid0 = 1'b1;
        bus.data0  = 8'h41;
        bus.last0  = 1'b1;
        #1;
        check("t1_idle_ack0", 32'(bus.ack0), 32'd0);
        check("t1_idle_busy", 32'(busy),     32'd0);
        cyc();
        #1;
        check("t1_busy",  32'(busy),        32'd1);
        check("t1_owner", 32'(owner),       32'd0);
        check("t1_ack0",  32'(bus.ack0),    32'd1);
        check("t1_wr",    32'(bus.wr_uart), 32'd1);
        check("t1_wdata", 32'(bus.w_data),  32'h41);
        cyc();
        idle_inputs();
        #1;
        check("t1_release_busy", 32'(busy),        32'd0);
        check("t1_release_wr",   32'(bus.wr_uart), 32'd0);

        // ---- 2: simultaneous 3-byte packets never interleave ----
        do_reset();
        log_q.delete();
        run_streams("ABC", "001", "xyz", "001", 100, open1);
        check_log("t2", "ABCxyz");
        check("t2_ack1_during_r0", 32'(open1), 32'd0);

        // ---- 3: round-robin alternation across back-to-back packets ----
        log_q.delete();
        run_streams("PQRS", "0101", "klmn", "0101", 100, open1);
        check_log("t3", "PQklRSmn");

        // ---- 4: long FIFO back-pressure never times out ----
        do_reset();
        bus.valid1 = 1'b1;
        bus.data1  = "U";
        bus.last1  = 1'b0;
        cyc();
        #1;
        check("t4_owner", 32'(owner),      32'd1);
        check("t4_ack1",  32'(bus.ack1),   32'd1);
        check("t4_wdata", 32'(bus.w_data), 32'("U"));
        cyc();
        bus.data1   = "V";
        bus.last1   = 1'b1;
        bus.tx_full = 1'b1;
        bad = 0;
        for (int j = 0; j < 500; j++) begin
            #1;
            if (bus.wr_uart !== 1'b0) bad++;
            if (abort_tick !== 1'b0) bad++;
            cyc();
        end
        check("t4_stall_quiet", 32'(bad), 32'd0);
        bus.tx_full = 1'b0;
        #1;
        check("t4_resume_wr",    32'(bus.wr_uart), 32'd1);
        check("t4_resume_wdata", 32'(bus.w_data),  32'("V"));
        check("t4_resume_ack0",  32'(bus.ack0),    32'd0);
        cyc();
        idle_inputs();
        #1;
        check("t4_done_busy", 32'(busy), 32'd0);

        // ---- 5: stalled owner dropped after TMO_MAX idle cycles ----
        do_reset();
        bus.valid0 = 1'b1;
        bus.data0  = "a";
        bus.last0  = 1'b0;
        bus.valid1 = 1'b1;
        bus.data1  = "b";
        bus.last1  = 1'b1;
        cyc();
        #1;
        check("t5_owner", 32'(owner),    32'd0);
        check("t5_ack0",  32'(bus.ack0), 32'd1);
        check("t5_ack1",  32'(bus.ack1), 32'd0);
        cyc();
        bus.valid0 = 1'b0;
        bad     = 0;
        n_abort = 0;
        for (int j = 1; j <= 400; j++) begin
            #1;
            if (bus.ack1 !== 1'b0) bad++;
            if (abort_tick === 1'b1) begin
                n_abort = j;
                break;
            end
            cyc();
        end
        check("t5_abort_delay", 32'(n_abort), 32'(c_TMO_MAX));
        check("t5_no_ack1_wait", 32'(bad), 32'd0);
        cyc();
        #1;
        check("t5_abort_pulse", 32'(abort_tick), 32'd0);
        check("t5_released",    32'(busy),       32'd0);
        cyc();
        #1;
        check("t5_r1_busy",  32'(busy),       32'd1);
        check("t5_r1_owner", 32'(owner),      32'd1);
        check("t5_r1_ack1",  32'(bus.ack1),   32'd1);
        check("t5_r1_wdata", 32'(bus.w_data), 32'("b"));

        // ---- 6: reset while a lock is held ----
        cyc();
        bus.data1  = "d";
        bus.last1  = 1'b0;
        cyc();
        bus.valid0 = 1'b1;
        bus.data0  = "c";
        bus.last0  = 1'b0;
        #1;
        check("t6_pre_owner", 32'(owner), 32'd1);
        check("t6_pre_busy",  32'(busy),  32'd1);
        reset = 1'b1;
        cyc();
        #1;
        check("t6_busy",  32'(busy),        32'd0);
        check("t6_ack0",  32'(bus.ack0),    32'd0);
        check("t6_ack1",  32'(bus.ack1),    32'd0);
        check("t6_wr",    32'(bus.wr_uart), 32'd0);
        check("t6_owner", 32'(owner),       32'd0);
        check("t6_abort", 32'(abort_tick),  32'd0);
        reset = 1'b0;
        cyc();
        #1;
        check("t6_rr_busy",  32'(busy),  32'd1);
        check("t6_rr_owner", 32'(owner), 32'd0);
        idle_inputs();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
